// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes, funct codes, PC-select encodings and trap vectors.
package mips_pkg;

  localparam logic [31:0] IRQ_VEC = 32'h80000004;
  localparam logic [31:0] EXC_VEC = 32'h80000008;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  typedef enum logic [2:0] {
    PCSRC_SEQ    = 3'd0,
    PCSRC_BRANCH = 3'd1,
    PCSRC_JUMP   = 3'd2,
    PCSRC_IRQ    = 3'd3,
    PCSRC_EXC    = 3'd4
  } pcsrc_e;

  function automatic logic op_defined(input logic [5:0] op);
    return (op[5:4] == 2'b00) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// ID-stage stall detection: load-use and branch/jr operands still in flight in EX or MEM.
module id_hazard_unit (
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rs,
  input  logic       uses_rt,
  input  logic       br_jr,
  input  logic       cmp_rt,
  input  logic       MemReadEX,
  input  logic       RegWriteEX,
  input  logic [4:0] WriteRegEX,
  input  logic       MemReadMEM,
  input  logic [4:0] WriteRegMEM,
  output logic       stall_req
);

  logic ex_rs, ex_rt, mem_rs, mem_rt, load_use, br_wait;

  always_comb begin
    // $0 is hardwired, so a match on index 0 never creates a dependency
    ex_rs  = (rs != 5'd0) && (WriteRegEX == rs);
    ex_rt  = (rt != 5'd0) && (WriteRegEX == rt);
    mem_rs = (rs != 5'd0) && (WriteRegMEM == rs);
    mem_rt = (rt != 5'd0) && (WriteRegMEM == rt);

    load_use = MemReadEX && ((uses_rs && ex_rs) || (uses_rt && ex_rt));
    br_wait  = br_jr && ((RegWriteEX && (ex_rs || (cmp_rt && ex_rt))) ||
                         (MemReadMEM && (mem_rs || (cmp_rt && mem_rt))));
    stall_req = load_use || br_wait;
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with ID-stage branch/jump/trap resolution and hazard stalls.
// Define IRQ_SYNC_EN to route interrupt through a 2-flop synchronizer.
module if_id_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instructionIF,
  input  logic [31:0] PCIF,
  input  logic [31:0] PCplus4IF,
  input  logic        interrupt,
  input  logic [31:0] rsdataID,
  input  logic [31:0] rtdataID,
  input  logic        MemReadEX,
  input  logic        RegWriteEX,
  input  logic [4:0]  WriteRegEX,
  input  logic        MemReadMEM,
  input  logic [4:0]  WriteRegMEM,
  output logic [31:0] instructionID,
  output logic [31:0] PCID,
  output logic [31:0] PCplus4ID,
  output logic        validID,
  output logic [2:0]  PCSrcID,
  output logic [31:0] branchaddrID,
  output logic [31:0] jumpaddrID,
  output logic        stall,
  output logic        flush,
  output logic        exception,
  output logic        epcWrite,
  output logic [31:0] epcID
);

  logic [31:0] instr_q, instr_d, pc_q, pc_d, pc4_q, pc4_d;
  logic        valid_q, valid_d, irq_pend_q, irq_pend_d;
  logic        irq_set, irq_take, hazard;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;
  logic        is_jr, is_jump, is_branch, taken, undef;
  logic        uses_rs, uses_rt, cmp_rt, br_jr;
  pcsrc_e      pcsrc;

`ifdef IRQ_SYNC_EN
  logic irq_s1_q, irq_s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_s1_q <= '0;
      irq_s2_q <= '0;
    end else begin
      irq_s1_q <= interrupt;
      irq_s2_q <= irq_s1_q;
    end
  end

  assign irq_set = irq_s2_q;
`else
  assign irq_set = interrupt;
`endif

  always_comb begin
    op    = instr_q[31:26];
    rs    = instr_q[25:21];
    rt    = instr_q[20:16];
    funct = instr_q[5:0];

    is_jr     = (op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
    is_jump   = (op == OP_J) || (op == OP_JAL);
    is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
                (op == OP_BGTZ) || ((op == OP_REGIMM) && (rt[4:1] == 4'd0));

    taken = 1'b0;
    unique case (op)
      OP_BEQ:    taken = (rsdataID == rtdataID);
      OP_BNE:    taken = (rsdataID != rtdataID);
      OP_BLEZ:   taken = rsdataID[31] || (rsdataID == '0);
      OP_BGTZ:   taken = !rsdataID[31] && (rsdataID != '0);
      OP_REGIMM: taken = (rt == 5'd0) ? rsdataID[31] : ((rt == 5'd1) && !rsdataID[31]);
      default:   taken = 1'b0;
    endcase

    uses_rs = 1'b0;
    uses_rt = 1'b0;
    cmp_rt  = (op == OP_BEQ) || (op == OP_BNE);
    if (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW) begin
      uses_rs = 1'b1;
      uses_rt = 1'b1;
    end else if (op == OP_REGIMM || op == OP_BLEZ || op == OP_BGTZ || op == OP_LW ||
                 (op[5:3] == 3'b001 && op != OP_LUI)) begin
      uses_rs = 1'b1;
    end
    // Bubbles carry no register dependencies
    uses_rs = uses_rs && valid_q;
    uses_rt = uses_rt && valid_q;
    br_jr   = valid_q && (is_branch || is_jr);
    undef   = valid_q && !op_defined(op);
  end

  id_hazard_unit u_hazard (
    .rs          (rs),
    .rt          (rt),
    .uses_rs     (uses_rs),
    .uses_rt     (uses_rt),
    .br_jr       (br_jr),
    .cmp_rt      (cmp_rt),
    .MemReadEX   (MemReadEX),
    .RegWriteEX  (RegWriteEX),
    .WriteRegEX  (WriteRegEX),
    .MemReadMEM  (MemReadMEM),
    .WriteRegMEM (WriteRegMEM),
    .stall_req   (hazard)
  );

  always_comb begin
    pcsrc     = PCSRC_SEQ;
    stall     = 1'b0;
    flush     = 1'b0;
    exception = 1'b0;
    epcWrite  = 1'b0;
    epcID     = '0;
    irq_take  = 1'b0;
    if (undef) begin
      pcsrc     = PCSRC_EXC;
      exception = 1'b1;
      flush     = 1'b1;
      epcWrite  = 1'b1;
      epcID     = pc4_q;
    end else if (irq_pend_q && valid_q && !pc_q[31]) begin
      pcsrc    = PCSRC_IRQ;
      irq_take = 1'b1;
      flush    = 1'b1;
      epcWrite = 1'b1;
      epcID    = pc_q;
    end else if (hazard) begin
      stall = 1'b1;
    end else if (valid_q && is_branch && taken) begin
      pcsrc = PCSRC_BRANCH;
      flush = 1'b1;
    end else if (valid_q && (is_jump || is_jr)) begin
      pcsrc = PCSRC_JUMP;
      flush = 1'b1;
    end
  end

  always_comb begin
    // A fresh request wins over the clear so a still-high level re-arms the pending flag
    irq_pend_d = irq_set || (irq_pend_q && !irq_take);
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    if (!stall) begin
      pc_d    = PCIF;
      pc4_d   = PCplus4IF;
      instr_d = flush ? '0 : instructionIF;
      valid_d = !flush;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q    <= '0;
      pc_q       <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign instructionID = instr_q;
  assign PCID          = pc_q;
  assign PCplus4ID     = pc4_q;
  assign validID       = valid_q;
  assign PCSrcID       = pcsrc;
  assign branchaddrID  = pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jumpaddrID    = is_jr ? rsdataID : {pc4_q[31:28], instr_q[25:0], 2'b00};

endmodule

// File: tb/tb_if_id_stage.sv
// Directed-vector bench for if_id_stage: decode table plus multi-cycle stall/trap/reset sequences.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instructionIF, PCIF, PCplus4IF, rsdataID, rtdataID;
  logic        interrupt, MemReadEX, RegWriteEX, MemReadMEM;
  logic [4:0]  WriteRegEX, WriteRegMEM;
  logic [31:0] instructionID, PCID, PCplus4ID, branchaddrID, jumpaddrID, epcID;
  logic        validID, stall, flush, exception, epcWrite;
  logic [2:0]  PCSrcID;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  if_id_stage dut (
    .clk(clk), .reset(reset), .instructionIF(instructionIF), .PCIF(PCIF),
    .PCplus4IF(PCplus4IF), .interrupt(interrupt), .rsdataID(rsdataID), .rtdataID(rtdataID),
    .MemReadEX(MemReadEX), .RegWriteEX(RegWriteEX), .WriteRegEX(WriteRegEX),
    .MemReadMEM(MemReadMEM), .WriteRegMEM(WriteRegMEM), .instructionID(instructionID),
    .PCID(PCID), .PCplus4ID(PCplus4ID), .validID(validID), .PCSrcID(PCSrcID),
    .branchaddrID(branchaddrID), .jumpaddrID(jumpaddrID), .stall(stall), .flush(flush),
    .exception(exception), .epcWrite(epcWrite), .epcID(epcID)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr, pc, rsv, rtv;
    logic        mr_ex, rw_ex;
    logic [4:0]  wr_ex;
    logic        mr_mem;
    logic [4:0]  wr_mem;
    logic [2:0]  pcsrc;
    logic        stl, fl, exc;
    int unsigned asel;  // 0 none, 1 branchaddr, 2 jumpaddr, 3 epcID
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add_vec(input string nm, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rsv, input logic [31:0] rtv,
                         input logic mr_ex, input logic rw_ex, input logic [4:0] wr_ex,
                         input logic mr_mem, input logic [4:0] wr_mem,
                         input logic [2:0] pcsrc, input logic stl, input logic fl, input logic exc,
                         input int unsigned asel, input logic [31:0] addr);
    vec_t v;
    v.name = nm; v.instr = instr; v.pc = pc; v.rsv = rsv; v.rtv = rtv;
    v.mr_ex = mr_ex; v.rw_ex = rw_ex; v.wr_ex = wr_ex; v.mr_mem = mr_mem; v.wr_mem = wr_mem;
    v.pcsrc = pcsrc; v.stl = stl; v.fl = fl; v.exc = exc; v.asel = asel; v.addr = addr;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic [31:0] instr, input logic [31:0] pc);
    instructionIF = instr;
    PCIF          = pc;
    PCplus4IF     = pc + 32'd4;
  endtask

  task automatic do_reset();
    interrupt = 1'b0; MemReadEX = 1'b0; RegWriteEX = 1'b0; WriteRegEX = '0;
    MemReadMEM = 1'b0; WriteRegMEM = '0; rsdataID = '0; rtdataID = '0;
    set_if(32'h0, 32'h0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int unsigned takes;
    bit          seen;

    add_vec("beq_taken",   32'h10220003, 32'h100, 5, 5, 0, 0, 0, 0, 0, 3'd1, 0, 1, 0, 1, 32'h110);
    add_vec("beq_nt",      32'h10220003, 32'h100, 5, 6, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 32'h110);
    add_vec("bne_taken",   32'h14220003, 32'h100, 5, 6, 0, 0, 0, 0, 0, 3'd1, 0, 1, 0, 1, 32'h110);
    add_vec("blez_zero",   32'h18200003, 32'h100, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0, 1, 0, 1, 32'h110);
    add_vec("bgtz_neg",    32'h1C20FFFF, 32'h100, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 32'h100);
    add_vec("bltz_taken",  32'h04200002, 32'h100, 32'h80000000, 0, 0, 0, 0, 0, 0, 3'd1, 0, 1, 0, 1, 32'h10C);
    add_vec("bgez_nt",     32'h04210002, 32'h100, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    add_vec("j",           32'h08100008, 32'h00400000, 0, 0, 0, 0, 0, 0, 0, 3'd2, 0, 1, 0, 2, 32'h00400020);
    add_vec("jr31",        32'h03E00008, 32'h100, 32'h00400020, 0, 0, 0, 0, 0, 0, 3'd2, 0, 1, 0, 2, 32'h00400020);
    add_vec("jr31_exhaz",  32'h03E00008, 32'h100, 32'h00400020, 0, 0, 1, 31, 0, 0, 3'd0, 1, 0, 0, 0, 0);
    add_vec("add_loaduse", 32'h01014820, 32'h100, 0, 0, 1, 1, 8, 0, 0, 3'd0, 1, 0, 0, 0, 0);
    add_vec("add_alu_ex",  32'h01014820, 32'h100, 0, 0, 0, 1, 8, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    add_vec("beq_memhaz",  32'h10220003, 32'h100, 5, 5, 0, 0, 0, 1, 2, 3'd0, 1, 0, 0, 0, 0);
    add_vec("undef_3f",    32'hFC000000, 32'h200, 0, 0, 0, 0, 0, 0, 0, 3'd4, 0, 1, 1, 3, 32'h204);
    add_vec("addi_r0",     32'h20050001, 32'h100, 0, 0, 1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    add_vec("lw_base_hit", 32'h8C620000, 32'h100, 0, 0, 1, 1, 3, 0, 0, 3'd0, 1, 0, 0, 0, 0);
    add_vec("lw_rt_nohaz", 32'h8C620000, 32'h100, 0, 0, 1, 1, 2, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    add_vec("sw_data_hit", 32'hAC620000, 32'h100, 0, 0, 1, 1, 2, 0, 0, 3'd0, 1, 0, 0, 0, 0);

    do_reset();
    check("reset.validID", {31'b0, validID}, 32'h0);
    check("reset.instructionID", instructionID, 32'h0);
    check("reset.pcsrc", {29'b0, PCSrcID}, 32'h0);
    check("reset.stall", {31'b0, stall}, 32'h0);

    foreach (vecs[i]) begin
      do_reset();
      set_if(vecs[i].instr, vecs[i].pc);
      rsdataID = vecs[i].rsv; rtdataID = vecs[i].rtv;
      MemReadEX = vecs[i].mr_ex; RegWriteEX = vecs[i].rw_ex; WriteRegEX = vecs[i].wr_ex;
      MemReadMEM = vecs[i].mr_mem; WriteRegMEM = vecs[i].wr_mem;
      step();
      check({vecs[i].name, ".valid"}, {31'b0, validID}, 32'h1);
      check({vecs[i].name, ".pcsrc"}, {29'b0, PCSrcID}, {29'b0, vecs[i].pcsrc});
      check({vecs[i].name, ".stall"}, {31'b0, stall}, {31'b0, vecs[i].stl});
      check({vecs[i].name, ".flush"}, {31'b0, flush}, {31'b0, vecs[i].fl});
      check({vecs[i].name, ".exc"}, {31'b0, exception}, {31'b0, vecs[i].exc});
      if (vecs[i].asel == 1) check({vecs[i].name, ".braddr"}, branchaddrID, vecs[i].addr);
      if (vecs[i].asel == 2) check({vecs[i].name, ".jaddr"}, jumpaddrID, vecs[i].addr);
      if (vecs[i].asel == 3) check({vecs[i].name, ".epc"}, epcID, vecs[i].addr);
    end

    // Load-use: hold one cycle, release when the load moves to MEM
    do_reset();
    set_if(32'h01014820, 32'h300);
    MemReadEX = 1'b1; RegWriteEX = 1'b1; WriteRegEX = 5'd8;
    step();
    check("lu.stall1", {31'b0, stall}, 32'h1);
    set_if(32'h00000000, 32'h304);
    step();
    check("lu.held_instr", instructionID, 32'h01014820);
    check("lu.held_pc", PCID, 32'h300);
    MemReadEX = 1'b0; RegWriteEX = 1'b0; MemReadMEM = 1'b1; WriteRegMEM = 5'd8;
    #1;
    check("lu.released", {31'b0, stall}, 32'h0);
    step();
    check("lu.advanced_pc", PCID, 32'h304);

    // Taken branch kills the instruction behind it
    do_reset();
    set_if(32'h10220003, 32'h100);
    rsdataID = 5; rtdataID = 5;
    step();
    check("br.flush", {31'b0, flush}, 32'h1);
    set_if(32'h2005ABCD, 32'h104);
    step();
    check("br.bubble_valid", {31'b0, validID}, 32'h0);
    check("br.bubble_instr", instructionID, 32'h0);
    check("br.bubble_pc", PCID, 32'h104);
    check("br.bubble_pcsrc", {29'b0, PCSrcID}, 32'h0);

    // jr waits on EX producer, then redirects
    do_reset();
    set_if(32'h03E00008, 32'h100);
    rsdataID = 32'h00400020; RegWriteEX = 1'b1; WriteRegEX = 5'd31;
    step();
    check("jrhaz.stall", {31'b0, stall}, 32'h1);
    step();
    check("jrhaz.held", instructionID, 32'h03E00008);
    RegWriteEX = 1'b0;
    #1;
    check("jrhaz.pcsrc", {29'b0, PCSrcID}, 32'h2);
    check("jrhaz.jaddr", jumpaddrID, 32'h00400020);

    // User-mode interrupt
    do_reset();
    set_if(32'h0, 32'h40);
    interrupt = 1'b1;
    step();
    interrupt = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      if (PCSrcID == 3'd3) seen = 1'b1;
      else step();
    end
    check("irq.taken", {31'b0, seen}, 32'h1);
    check("irq.epcwrite", {31'b0, epcWrite}, 32'h1);
    check("irq.epc", epcID, 32'h40);
    check("irq.flush", {31'b0, flush}, 32'h1);
    set_if(32'h0, 32'h44);
    step();
    step();
    check("irq.cleared_valid", {31'b0, validID}, 32'h1);
    check("irq.cleared_pcsrc", {29'b0, PCSrcID}, 32'h0);

    // Kernel mode masks the interrupt until a user PC reaches ID
    do_reset();
    set_if(32'h0, 32'h80000010);
    interrupt = 1'b1;
    step();
    interrupt = 1'b0;
    takes = 0;
    for (int k = 0; k < 4; k++) begin
      if (PCSrcID == 3'd3) takes++;
      step();
    end
    check("kirq.masked", takes, 32'h0);
    set_if(32'h0, 32'h50);
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      step();
      if (PCSrcID == 3'd3) seen = 1'b1;
    end
    check("kirq.taken_user", {31'b0, seen}, 32'h1);
    check("kirq.epc", epcID, 32'h50);

    // Undefined opcode wins over a pending interrupt
    do_reset();
    set_if(32'h0, 32'h80000010);
    interrupt = 1'b1;
    step();
    interrupt = 1'b0;
    step();
    step();
    set_if(32'hFC000000, 32'h200);
    step();
    check("undef_irq.exc", {31'b0, exception}, 32'h1);
    check("undef_irq.pcsrc", {29'b0, PCSrcID}, 32'h4);
    check("undef_irq.epc", epcID, 32'h204);
    check("undef_irq.stall", {31'b0, stall}, 32'h0);
    set_if(32'h0, 32'h208);
    step();
    step();
    check("undef_irq.irq_after", {29'b0, PCSrcID}, 32'h3);

    // Asynchronous reset mid-stall
    do_reset();
    set_if(32'h01014820, 32'h300);
    MemReadEX = 1'b1; WriteRegEX = 5'd8;
    step();
    check("rststall.pre", {31'b0, stall}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rststall.instr", instructionID, 32'h0);
    check("rststall.valid", {31'b0, validID}, 32'h0);
    check("rststall.pcsrc", {29'b0, PCSrcID}, 32'h0);
    check("rststall.stall", {31'b0, stall}, 32'h0);
    #1;
    reset = 1'b0;
    step();
    check("rststall.post_pcsrc", {29'b0, PCSrcID}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register plus ID-stage control resolution for the 5-stage MIPS pipeline.
- Captures the fetch-stage outputs and resolves branches, jumps, jr/jalr, interrupts and undefined-instruction exceptions in ID.
- Detects load-use and branch-operand hazards.
- Drives the fetch stage's PC-select, target addresses, stall, flush and exception controls.

Parameters:
- IRQ_VEC, 32'h80000004, interrupt handler address (selected by PCSrcID=3 in fetch).
- EXC_VEC, 32'h80000008, exception handler address (selected by PCSrcID=4 in fetch).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- instructionIF  input  32  instruction from fetch (already zeroed by fetch when flush=1)
- PCIF  input  32  PC of instructionIF
- PCplus4IF  input  32  PCIF+4
- interrupt  input  1  external interrupt request, level
- rsdataID  input  32  forwarded rs operand for branch compare / jr target
- rtdataID  input  32  forwarded rt operand for branch compare
- MemReadEX  input  1  instruction in EX is a load
- RegWriteEX  input  1  instruction in EX writes a register
- WriteRegEX  input  5  destination register of EX
- MemReadMEM  input  1  instruction in MEM is a load
- WriteRegMEM  input  5  destination register of MEM
- instructionID  output  32  registered instruction
- PCID  output  32  registered PC
- PCplus4ID  output  32  registered PC+4
- validID  output  1  ID holds a fetched instruction rather than a flush bubble
- PCSrcID  output  3  0=seq, 1=branch, 2=jump/jr, 3=interrupt, 4=exception
- branchaddrID  output  32  PCplus4ID + (sign-extended imm16 << 2)
- jumpaddrID  output  32  jr/jalr: rsdataID; j/jal: {PCplus4ID[31:28], imm26, 2'b00}
- stall  output  1  hold PC and IF/ID
- flush  output  1  kill instruction in IF
- exception  output  1  undefined instruction taken this cycle
- epcWrite  output  1  write epcID to $26 this cycle
- epcID  output  32  return address

Behaviour:
- Reset: instructionID=0, PCID=0, PCplus4ID=0, validID=0, irq_pend=0. All outputs derived from these are therefore 0 or inactive.
- Register update at posedge clk:
  - stall=1: hold all registers.
  - else flush=1: load instruction 0 and validID=0; PCID/PCplus4ID still load PCIF/PCplus4IF.
  - else: load IF values with validID=1.
- Decode fields: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
- Branch set:
  - beq 04 taken if rs==rt; bne 05 taken if rs!=rt.
  - blez 06 taken if rs signed <=0; bgtz 07 taken if rs signed >0.
  - REGIMM 01 with rt=0 (bltz) taken if rs<0; rt=1 (bgez) taken if rs>=0.
- Jump set: op 02 j, op 03 jal; op 00 with funct 08 jr or funct 09 jalr.
- Defined opcodes: 00–0F, 23 (lw), 2B (sw). All others are undefined when validID=1.
- Hazard, with uses_rs / uses_rt derived from the decoded opcode and register index !=0 required for every match:
  - Load-use: stall when MemReadEX and WriteRegEX matches a used rs/rt.
  - Branch/jr operand not ready: stall when the instruction is a branch or jr/jalr and either
    - RegWriteEX with WriteRegEX matching a compared register, or
    - MemReadMEM with WriteRegMEM matching a compared register.
- irq_pend: set when interrupt=1, cleared in the cycle the interrupt is taken. Set has priority over clear only if interrupt is still high.
- Combinational control, priority high to low:
  1. validID and undefined opcode: PCSrcID=4, exception=1, flush=1, stall=0, epcWrite=1, epcID=PCplus4ID.
  2. irq_pend and validID and PCID[31]==0 (user mode): PCSrcID=3, flush=1, stall=0, epcWrite=1, epcID=PCID. The ID instruction is discarded and re-executed after return.
  3. hazard: stall=1, PCSrcID=0, flush=0. Fetch holds its PC.
  4. taken branch: PCSrcID=1, flush=1.
  5. jump or jr: PCSrcID=2, flush=1.
  6. otherwise: PCSrcID=0, all strobes 0.
- Interrupts are masked while PCID[31]=1 (kernel); they remain pending until a user-mode valid instruction reaches ID.
- Bubbles (validID=0) never trigger exception, interrupt, branch or stall.
- Reset mid-stall: all state clears immediately (asynchronous); the first post-reset cycle has PCSrcID=0.

Optional Feature:
- IRQ_SYNC_EN defined: interrupt passes through a 2-flop synchronizer (reset to 0) before setting irq_pend; adds 2 cycles of latency.
- IRQ_SYNC_EN undefined: interrupt sets irq_pend directly at the next edge.

Decomposition:
- Package mips_pkg holds:
  - opcode/funct constants;
  - PCSRC_SEQ/BRANCH/JUMP/IRQ/EXC encodings (0–4);
  - IRQ_VEC and EXC_VEC defaults.
- One combinational sub-module, id_hazard_unit: takes decoded rs/rt, uses flags, branch/jr flag and EX/MEM destination info; outputs the stall request.

Test Plan:
- Load-use: EX `lw $8` (MemReadEX=1, WriteRegEX=8); ID `add $9,$8,$1` -> stall=1 for 1 cycle, IF/ID held; next cycle stall=0.
- Taken branch: ID `beq $1,$2,+3` with PCID=0x100, rsdata=rtdata=5 -> PCSrcID=1, branchaddrID=0x110, flush=1; next cycle validID=0.
- Jump register: ID `jr $31` with rsdata=0x00400020 and no hazard -> PCSrcID=2, jumpaddrID=0x00400020, flush=1. With RegWriteEX=1 and WriteRegEX=31 -> stall=1 first.
- Interrupt: interrupt pulsed while PCID=0x00000040 (valid) -> PCSrcID=3, epcWrite=1, epcID=0x40, irq_pend cleared. With PCID=0x80000010 -> no take until a user-mode PC reaches ID.
- Undefined instruction: op=0x3F at PCID=0x200 -> exception=1, PCSrcID=4, epcID=0x204. Beats a simultaneous pending interrupt and a hazard.
- Reset asserted during stall -> instructionID=0, validID=0, PCSrcID=0, stall=0 immediately.
